retire_drive_sync_fifo: RTL and testbench



---
 rtl/retire_drive_sync_fifo.sv | 60 ++++++
 tb/tb_retire_drive_sync_fifo.sv | 130 +++++++++++++
 2 files changed

// File: rtl/retire_drive_sync_fifo.sv
// retire_drive_sync_fifo: two-phase drive/free channel into a clocked valid/ready FIFO
// Optional macro DRIVE_SYNC3_EN adds a third synchroniser stage on i_drive.
module retire_drive_sync_fifo #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_drive,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_free,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [CNT_W-1:0]      o_count
);
  localparam int PW = $clog2(DEPTH);
  logic s1_q, s1_d, s2_q, s2_d, s_prev_q, s_prev_d, free_q, free_d, ev_src, push, pop;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
`ifdef DRIVE_SYNC3_EN
  logic s3_q, s3_d;
  always_comb s3_d = rst ? 1'b0 : s2_q;
  always_ff @(posedge clk) s3_q <= s3_d;
  assign ev_src = s3_q;
`else
  assign ev_src = s2_q;
`endif
  // A full FIFO still accepts the word when the head leaves on the same edge
  assign pop  = (cnt_q != '0) && i_ready;
  assign push = (ev_src != s_prev_q) && ((cnt_q != CNT_W'(DEPTH)) || pop);
  always_comb begin
    s1_d     = rst ? 1'b0 : i_drive;
    s2_d     = rst ? 1'b0 : s1_q;
    s_prev_d = rst ? 1'b0 : (push ? ev_src : s_prev_q);
    free_d   = rst ? 1'b0 : (push ? ~free_q : free_q);
    wr_d     = rst ? '0 : (push ? wr_q + 1'b1 : wr_q);
    rd_d     = rst ? '0 : (pop ? rd_q + 1'b1 : rd_q);
    cnt_d    = rst ? '0 : cnt_q + CNT_W'(push) - CNT_W'(pop);
    mem_d    = mem_q;
    if (push) mem_d[wr_q] = i_data;
  end
  always_ff @(posedge clk) begin
    s1_q     <= s1_d;
    s2_q     <= s2_d;
    s_prev_q <= s_prev_d;
    free_q   <= free_d;
    wr_q     <= wr_d;
    rd_q     <= rd_d;
    cnt_q    <= cnt_d;
    mem_q    <= mem_d;
  end
  assign o_free  = free_q;
  assign o_valid = (cnt_q != '0);
  assign o_data  = mem_q[rd_q];
  assign o_count = cnt_q;
endmodule

// File: tb/tb_retire_drive_sync_fifo.sv
// tb_retire_drive_sync_fifo: directed checks of handshake latency, fill/stall, wrap and reset
module tb_retire_drive_sync_fifo;
`ifdef DRIVE_SYNC3_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk = 0, rst = 1, i_drive = 0, i_ready = 0, o_free, o_valid;
  logic [11:0] i_data = '0, o_data;
  logic [2:0] o_count;
  int n_cmp = 0, n_err = 0;
  logic exp_free = 0;

  retire_drive_sync_fifo dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready), .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [11:0] d);
    i_data = d;
    i_drive = ~i_drive;
    for (int k = 0; k < 20 && o_free !== i_drive; k++) @(negedge clk);
    chk("send_ack", o_free, i_drive);
    exp_free = i_drive;
  endtask

  task automatic state(input string tag, input logic f, input logic v, input logic [2:0] c);
    chk({tag, "_free"}, o_free, f);
    chk({tag, "_valid"}, o_valid, v);
    chk({tag, "_count"}, o_count, c);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      state("idle", 0, 0, 0);
    end
    // single word: toggle before edge 0, answered on edge LAT
    i_data = 12'h5A3;
    i_drive = 1;
    repeat (LAT) @(negedge clk);
    state("single_pre", 0, 0, 0);
    @(negedge clk);
    state("single", 1, 1, 1);
    chk("single_data", o_data, 12'h5A3);
    exp_free = 1;
    i_ready = 1;
    @(negedge clk);
    i_ready = 0;
    state("single_pop", 1, 0, 0);
    // fill four, fifth stalls
    for (int i = 1; i <= 4; i++) send(12'(i));
    state("full", exp_free, 1, 4);
    i_data = 12'h005;
    i_drive = ~i_drive;
    repeat (LAT + 6) @(negedge clk);
    state("stall", exp_free, 1, 4);
    chk("stall_head", o_data, 12'h001);
    i_ready = 1;
    @(negedge clk);
    i_ready = 0;
    exp_free = ~exp_free;
    state("pushpop", exp_free, 1, 4);
    chk("pushpop_head", o_data, 12'h002);
    // second simultaneous push/pop at full
    i_data = 12'h006;
    i_drive = ~i_drive;
    repeat (LAT + 3) @(negedge clk);
    state("stall2", exp_free, 1, 4);
    i_ready = 1;
    @(negedge clk);
    i_ready = 0;
    exp_free = ~exp_free;
    state("pushpop2", exp_free, 1, 4);
    for (int i = 3; i <= 6; i++) begin
      chk("drain_data", o_data, 12'(i));
      i_ready = 1;
      @(negedge clk);
      i_ready = 0;
      chk("drain_count", o_count, 3'(6 - i));
    end
    state("drained", exp_free, 0, 0);
    send(12'h007);
    send(12'h008);
    chk("wrap_count", o_count, 2);
    chk("wrap_data7", o_data, 12'h007);
    i_ready = 1;
    @(negedge clk);
    chk("wrap_data8", o_data, 12'h008);
    @(negedge clk);
    i_ready = 0;
    state("wrap_empty", exp_free, 0, 0);
    // reset mid-stream: three queued plus one pending
    send(12'h111);
    send(12'h222);
    send(12'h333);
    i_data = 12'h444;
    i_drive = ~i_drive;
    @(negedge clk);
    state("pre_rst", exp_free, 1, 3);
    rst = 1;
    i_drive = 0;
    @(negedge clk);
    rst = 0;
    state("rst", 0, 0, 0);
    repeat (LAT + 3) @(negedge clk);
    state("post_rst_idle", 0, 0, 0);
    i_data = 12'hABC;
    i_drive = 1;
    repeat (LAT) @(negedge clk);
    state("abc_pre", 0, 0, 0);
    @(negedge clk);
    state("abc", 1, 1, 1);
    chk("abc_data", o_data, 12'hABC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
